// File: rtl/spi_regif_pkg.sv
// Shared types and command/mode field definitions for the SPI burst register interface.
package spi_regif_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam int CMD_WIDTH     = 8;
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_SPACE_BIT = 6;
  localparam int CMD_ADDR_MSB  = 5;
  localparam int CMD_ADDR_LSB  = 0;

  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam logic SPACE_CONFIG = 1'b0;
  localparam logic SPACE_STATUS = 1'b1;

endpackage

// File: rtl/spi_regif_shifter.sv
// SPI edge detection, bit counting, MOSI shift-in and MISO shift-out.
// The per-frame cpol/cpha are captured on start.
module spi_regif_shifter
  import spi_regif_pkg::*;
#(
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 active,
  input  logic                 data_phase,
  input  logic [1:0]           mode,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 load,
  input  logic                 drive_en,
  input  logic [REG_WIDTH-1:0] load_data,
  output logic [REG_WIDTH-1:0] shift_data,
  output logic                 word_end,
  output logic                 miso
);

  localparam int CNT_W = $clog2(REG_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(REG_WIDTH - 1);

  logic                 sclk_q;
  logic                 cpol;
  logic                 cpha;
  logic [CNT_W-1:0]     count;
  logic [REG_WIDTH-1:0] out_sr;
  logic                 prime;
  logic                 rise;
  logic                 fall;
  logic                 lead;
  logic                 trail;
  logic                 sample;
  logic                 shift_edge;
  logic                 emit;

  // With cpha=0 the MSB is primed right after a load; the trailing edge that
  // ends the previous bit (count wrapped to 0) must not advance the word.
  always_comb begin
    rise       = sclk & ~sclk_q;
    fall       = ~sclk & sclk_q;
    lead       = cpol ? fall : rise;
    trail      = cpol ? rise : fall;
    sample     = active & (cpha ? trail : lead);
    shift_edge = active & (cpha ? lead : trail);
    word_end   = sample & (count == (data_phase ? LAST_DATA : LAST_CMD));
    emit       = drive_en & (cpha ? shift_edge : (prime | (shift_edge & (count != '0))));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_q     <= 1'b0;
      cpol       <= 1'b0;
      cpha       <= 1'b0;
      count      <= '0;
      shift_data <= '0;
      out_sr     <= '0;
      prime      <= 1'b0;
      miso       <= 1'b0;
    end else if (ena) begin
      sclk_q <= sclk;

      if (start) begin
        cpol  <= mode[MODE_CPOL_BIT];
        cpha  <= mode[MODE_CPHA_BIT];
        count <= '0;
      end else if (sample) begin
        shift_data <= {shift_data[REG_WIDTH-2:0], mosi};
        count      <= word_end ? '0 : count + CNT_W'(1);
      end

      prime <= 1'b0;
      if (!drive_en) begin
        miso <= 1'b0;
      end else if (load) begin
        out_sr <= load_data;
        prime  <= ~cpha;
      end else if (emit) begin
        miso   <= out_sr[REG_WIDTH-1];
        out_sr <= {out_sr[REG_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_burst_regif.sv
// SPI target with burst config-write / config-or-status read, auto-increment with wrap.
// Define SPI_REGIF_SYNC_EN to add two-stage input synchronisers on cs/clk/mosi/mode.
module spi_burst_regif
  import spi_regif_pkg::*;
#(
  parameter int                   NUM_REGS      = 16,
  parameter int                   REG_WIDTH     = 8,
  parameter int                   ADDR_WIDTH    = $clog2(NUM_REGS),
  parameter logic [REG_WIDTH-1:0] CFG_RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          ena,
  input  logic [1:0]                    mode,
  input  logic                          spi_cs_n,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic [NUM_REGS*REG_WIDTH-1:0] config_regs,
  input  logic [NUM_REGS*REG_WIDTH-1:0] status_regs,
  output logic                          wr_pulse,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic                          busy
);

  logic [1:0] mode_s;
  logic       cs_n_s;
  logic       sclk_s;
  logic       mosi_s;

`ifdef SPI_REGIF_SYNC_EN
  logic [4:0] sync1;
  logic [4:0] sync2;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1 <= 5'b00100;
      sync2 <= 5'b00100;
    end else if (ena) begin
      sync1 <= {mode, spi_cs_n, spi_clk, spi_mosi};
      sync2 <= sync1;
    end
  end

  assign {mode_s, cs_n_s, sclk_s, mosi_s} = sync2;
`else
  assign {mode_s, cs_n_s, sclk_s, mosi_s} = {mode, spi_cs_n, spi_clk, spi_mosi};
`endif

  state_t                state;
  state_t                state_nxt;
  logic                  cmd_done_q;
  logic                  data_done_q;
  logic                  first_q;
  logic                  is_write;
  logic                  space;
  logic                  oor;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [REG_WIDTH-1:0]  cfg [NUM_REGS];
  logic                  start;
  logic                  active;
  logic                  data_phase;
  logic                  cmd_latch;
  logic                  drive_en;
  logic                  load;
  logic                  commit;
  logic [REG_WIDTH-1:0]  shift_data;
  logic [REG_WIDTH-1:0]  load_data;
  logic [CMD_WIDTH-1:0]  cmd;
  logic                  word_end;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!cs_n_s) state_nxt = CMD;
      CMD: begin
        if (cs_n_s) state_nxt = IDLE;
        else if (cmd_done_q) state_nxt = DATA;
      end
      DATA: if (cs_n_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The commit is not qualified by state so that a word whose final sample
  // edge coincides with chip-select release still lands.
  always_comb begin
    busy       = (state != IDLE);
    active     = (state != IDLE);
    data_phase = (state == DATA);
    start      = (state == IDLE) && !cs_n_s;
    cmd_latch  = (state == CMD) && !cs_n_s && cmd_done_q;
    drive_en   = (state == DATA) && !is_write;
    load       = drive_en && (first_q || data_done_q);
    commit     = data_done_q && is_write && !oor;
  end

  assign cmd = shift_data[CMD_WIDTH-1:0];

  always_comb begin
    addr_inc = (int'(addr) == NUM_REGS - 1) ? '0 : addr + ADDR_WIDTH'(1);
  end

  always_comb begin
    load_data = '0;
    if (!oor) begin
      if (space == SPACE_STATUS) load_data = status_regs[int'(addr)*REG_WIDTH +: REG_WIDTH];
      else load_data = cfg[addr];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      first_q     <= 1'b0;
      is_write    <= 1'b0;
      space       <= 1'b0;
      oor         <= 1'b0;
      addr        <= '0;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) cfg[i] <= CFG_RESET_VAL;
    end else if (ena) begin
      cmd_done_q  <= word_end && (state == CMD);
      data_done_q <= word_end && (state == DATA);
      first_q     <= cmd_latch && !cmd[CMD_WRITE_BIT];
      wr_pulse    <= commit;
      if (cmd_latch) begin
        is_write <= cmd[CMD_WRITE_BIT];
        space    <= cmd[CMD_SPACE_BIT];
        addr     <= cmd[ADDR_WIDTH-1:0];
        // Covers both nonzero upper address bits and holes above NUM_REGS-1.
        oor      <= int'(cmd[CMD_ADDR_MSB:CMD_ADDR_LSB]) >= NUM_REGS;
      end else if (commit) begin
        cfg[addr] <= shift_data;
        wr_addr   <= addr;
        addr      <= addr_inc;
      end else if (load && !oor) begin
        addr <= addr_inc;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) config_regs[i*REG_WIDTH +: REG_WIDTH] = cfg[i];
  end

  spi_regif_shifter #(
    .REG_WIDTH(REG_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rstb      (rstb),
    .ena       (ena),
    .start     (start),
    .active    (active),
    .data_phase(data_phase),
    .mode      (mode_s),
    .sclk      (sclk_s),
    .mosi      (mosi_s),
    .load      (load),
    .drive_en  (drive_en),
    .load_data (load_data),
    .shift_data(shift_data),
    .word_end  (word_end),
    .miso      (spi_miso)
  );

endmodule

// File: tb/tb_spi_burst_regif.sv
// Directed bench for spi_burst_regif: table of SPI frames plus reset/CS-edge corner sequences.
module tb_spi_burst_regif;

  localparam int H = 5;

  logic         clk = 1'b0;
  logic         rstb;
  logic         ena;
  logic [1:0]   mode;
  logic         spi_cs_n;
  logic         spi_clk;
  logic         spi_mosi;
  logic         spi_miso;
  logic [127:0] config_regs;
  logic [127:0] status_regs;
  logic         wr_pulse;
  logic [3:0]   wr_addr;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;

  always #5 clk = ~clk;

  spi_burst_regif #(
    .NUM_REGS     (16),
    .REG_WIDTH    (8),
    .CFG_RESET_VAL(8'h00)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .mode       (mode),
    .spi_cs_n   (spi_cs_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .config_regs(config_regs),
    .status_regs(status_regs),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

  always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

  typedef struct {
    logic [1:0]  mode;
    int          nbits;
    logic [63:0] tx;
    logic [63:0] rx;
    int          reg_idx;
    logic [7:0]  reg_val;
    int          pulses;
    int          last_addr;
  } vec_t;

  vec_t vecs[12];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic cpol, input logic cpha, input logic b,
                         input logic last_cs, output logic r);
    if (!cpha) begin
      spi_mosi = b;
      tick(H);
      r = spi_miso;
      spi_clk = ~cpol;
      if (last_cs) begin
        spi_cs_n = 1'b1;
        return;
      end
      tick(H);
      spi_clk = cpol;
    end else begin
      spi_clk  = ~cpol;
      spi_mosi = b;
      tick(H);
      r = spi_miso;
      spi_clk = cpol;
      if (last_cs) begin
        spi_cs_n = 1'b1;
        return;
      end
      tick(H);
    end
  endtask

  task automatic frame(input logic [1:0] m, input int nbits, input logic [63:0] tx,
                       input logic cs_last, output logic [63:0] rx);
    logic r;
    mode    = m;
    spi_clk = m[1];
    tick(2);
    spi_cs_n = 1'b0;
    tick(H);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(m[1], m[0], tx[nbits-1-i], cs_last && (i == nbits - 1), r);
      rx = {rx[62:0], r};
    end
    if (!cs_last) begin
      tick(H);
      spi_cs_n = 1'b1;
      tick(4);
    end
  endtask

  initial begin
    logic [63:0] rx;
    logic [63:0] tx;
    logic        r;
    int          p0;

    rstb = 1'b0; ena = 1'b1; mode = 2'b00;
    spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    for (int n = 0; n < 16; n++) status_regs[n*8 +: 8] = 8'hC0 + 8'(n);
    status_regs[7:0]  = 8'hCA;
    status_regs[15:8] = 8'h10;

    vecs[0]  = '{2'd0, 16, 64'h82A5,     64'h0,        2,  8'hA5, 1, 2};
    vecs[1]  = '{2'd3, 32, 64'h8F112233, 64'h0,        15, 8'h11, 3, 1};
    vecs[2]  = '{2'd1, 32, 64'h0F000000, 64'h00112233, 0,  8'h22, 0, 0};
    vecs[3]  = '{2'd1, 24, 64'h400000,   64'h00CA10,   1,  8'h33, 0, 0};
    vecs[4]  = '{2'd2, 13, 64'h1076,     64'h0,        3,  8'h00, 0, 0};
    vecs[5]  = '{2'd2, 16, 64'h835A,     64'h0,        3,  8'h5A, 1, 3};
    vecs[6]  = '{2'd2, 16, 64'hBF55,     64'h0,        15, 8'h11, 0, 0};
    vecs[7]  = '{2'd0, 16, 64'h3F00,     64'h0,        15, 8'h11, 0, 0};
    vecs[8]  = '{2'd1, 16, 64'h0200,     64'h00A5,     2,  8'hA5, 0, 0};
    vecs[9]  = '{2'd2, 24, 64'h4F0000,   64'h00CFCA,   15, 8'h11, 0, 0};
    vecs[10] = '{2'd3, 16, 64'h4100,     64'h0010,     0,  8'h22, 0, 0};
    vecs[11] = '{2'd0, 24, 64'h0F0000,   64'h001122,   1,  8'h33, 0, 0};

    tick(2);
    chk("rst cfg_lo", config_regs[63:0], 64'h0);
    chk("rst cfg_hi", config_regs[127:64], 64'h0);
    chk("rst miso", spi_miso, 0);
    chk("rst wr_pulse", wr_pulse, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst busy", busy, 0);
    rstb = 1'b1;
    tick(2);

    for (int v = 0; v < 12; v++) begin
      p0 = pulse_cnt;
      frame(vecs[v].mode, vecs[v].nbits, vecs[v].tx, 1'b0, rx);
      chk($sformatf("v%0d rx", v), rx, vecs[v].rx);
      chk($sformatf("v%0d cfg%0d", v, vecs[v].reg_idx),
          config_regs[vecs[v].reg_idx*8 +: 8], vecs[v].reg_val);
      chk($sformatf("v%0d pulses", v), pulse_cnt - p0, vecs[v].pulses);
      if (vecs[v].pulses > 0) chk($sformatf("v%0d wr_addr", v), wr_addr, vecs[v].last_addr);
      chk($sformatf("v%0d busy", v), busy, 0);
    end

    // CS released together with the final sample edge; commit lands two clocks later.
    p0 = pulse_cnt;
    frame(2'd0, 16, 64'h843C, 1'b1, rx);
    tick(1);
    chk("cs_last early", wr_pulse, 0);
    tick(1);
    chk("cs_last pulse", wr_pulse, 1);
    chk("cs_last wr_addr", wr_addr, 4);
    chk("cs_last cfg4", config_regs[39:32], 8'h3C);
    tick(1);
    chk("cs_last pulse width", wr_pulse, 0);
    spi_clk = 1'b0;
    tick(2);
    chk("cs_last busy", busy, 0);
    chk("cs_last count", pulse_cnt - p0, 1);

    // Reset in the middle of a burst, after one word has committed.
    mode = 2'd0; spi_clk = 1'b0;
    tick(2);
    spi_cs_n = 1'b0;
    tick(H);
    tx = 64'h42BBD;
    for (int i = 0; i < 19; i++) spi_bit(1'b0, 1'b0, tx[18-i], 1'b0, r);
    chk("mid busy", busy, 1);
    chk("mid cfg5", config_regs[47:40], 8'h77);
    chk("mid wr_addr", wr_addr, 5);
    rstb = 1'b0;
    tick(1);
    for (int n = 0; n < 16; n++) chk($sformatf("arst cfg%0d", n), config_regs[n*8 +: 8], 8'h00);
    chk("arst busy", busy, 0);
    chk("arst miso", spi_miso, 0);
    chk("arst wr_addr", wr_addr, 0);
    spi_cs_n = 1'b1; spi_clk = 1'b0;
    tick(2);
    rstb = 1'b1;
    tick(2);

    p0 = pulse_cnt;
    frame(2'd0, 16, 64'h8199, 1'b0, rx);
    chk("post cfg1", config_regs[15:8], 8'h99);
    chk("post pulses", pulse_cnt - p0, 1);
    chk("post cfg5", config_regs[47:40], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
